// File: rtl/mul_share_arbiter_if.sv
// Bundle of the requester-side and multiplier-side handshake signals for mul_share_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mul_share_arbiter_if #(
    parameter int MUL_WIDTH = 4
);
    logic [1:0]             in_valid;
    logic [1:0]             in_ready;
    logic [2*MUL_WIDTH-1:0] in_multiplicand;
    logic [2*MUL_WIDTH-1:0] in_multiplier;
    logic [1:0]             out_valid;
    logic [1:0]             out_ready;
    logic [2*MUL_WIDTH-1:0] out_product;
    logic                   mul_src_valid;
    logic                   mul_src_ready;
    logic [MUL_WIDTH-1:0]   mul_multiplicand;
    logic [MUL_WIDTH-1:0]   mul_multiplier;
    logic                   mul_dest_valid;
    logic                   mul_dest_ready;
    logic [2*MUL_WIDTH-1:0] mul_product;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, out_ready,
               mul_src_ready, mul_dest_valid, mul_product,
        output in_ready, out_valid, out_product, mul_src_valid,
               mul_multiplicand, mul_multiplier, mul_dest_ready
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, out_ready,
               mul_src_ready, mul_dest_valid, mul_product,
        input  in_ready, out_valid, out_product, mul_src_valid,
               mul_multiplicand, mul_multiplier, mul_dest_ready
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Shares one sequential signed multiplier between two requesters, one operation in flight,
// with round-robin grant and result held until the owning lane accepts it.
module mul_share_arbiter #(
    parameter int MUL_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   lastServed_q, lastServed_d;
    logic                   owner_q, owner_d;
    logic [MUL_WIDTH-1:0]   opA_q, opA_d;
    logic [MUL_WIDTH-1:0]   opB_q, opB_d;
    logic [2*MUL_WIDTH-1:0] result_q, result_d;

    logic                   grantValid;
    logic                   grantLane;
    logic [1:0]             inReady;
    logic [1:0]             outValid;
    logic                   mulSrcValid;
    logic                   mulDestReady;

    // With both lanes requesting, the lane that was not served last wins.
    always_comb begin
        grantValid = |bus.in_valid;
        grantLane  = 1'b0;
        if (bus.in_valid == 2'b11) begin
            grantLane = ~lastServed_q;
        end else if (bus.in_valid == 2'b10) begin
            grantLane = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        lastServed_d = lastServed_q;
        owner_d      = owner_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        result_d     = result_q;
        inReady      = 2'b00;
        outValid     = 2'b00;
        mulSrcValid  = 1'b0;
        mulDestReady = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    inReady = grantLane ? 2'b10 : 2'b01;
                    owner_d = grantLane;
                    opA_d   = grantLane ? bus.in_multiplicand[2*MUL_WIDTH-1:MUL_WIDTH]
                                        : bus.in_multiplicand[MUL_WIDTH-1:0];
                    opB_d   = grantLane ? bus.in_multiplier[2*MUL_WIDTH-1:MUL_WIDTH]
                                        : bus.in_multiplier[MUL_WIDTH-1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mulSrcValid = 1'b1;
                if (bus.mul_src_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mulDestReady = 1'b1;
                if (bus.mul_dest_valid) begin
                    result_d = bus.mul_product;
                    state_d  = RESP;
                end
            end
            RESP: begin
                outValid = owner_q ? 2'b10 : 2'b01;
                if (bus.out_ready[owner_q]) begin
                    lastServed_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset favours lane 0 on the first contested grant by marking lane 1 as last served.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lastServed_q <= 1'b1;
            owner_q      <= 1'b0;
            opA_q        <= '0;
            opB_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            lastServed_q <= lastServed_d;
            owner_q      <= owner_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            result_q     <= result_d;
        end
    end

    assign bus.in_ready         = inReady;
    assign bus.out_valid        = outValid;
    assign bus.out_product      = result_q;
    assign bus.mul_src_valid    = mulSrcValid;
    assign bus.mul_multiplicand = opA_q;
    assign bus.mul_multiplier   = opB_q;
    assign bus.mul_dest_ready   = mulDestReady;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small latency-3 signed multiplier attached.
module tb_mul_share_arbiter;
    localparam int MUL_WIDTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;

    mul_share_arbiter_if #(.MUL_WIDTH(MUL_WIDTH)) bus ();

    mul_share_arbiter #(.MUL_WIDTH(MUL_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached multiplier: accepts one operand pair, answers after a short fixed delay.
    logic              mulHave;
    logic [1:0]        mulCnt;
    logic signed [7:0] mulProd;
    logic signed [7:0] mulA;
    logic signed [7:0] mulB;
    logic              srcReadyEn;

    assign mulA               = {{4{bus.mul_multiplicand[3]}}, bus.mul_multiplicand};
    assign mulB               = {{4{bus.mul_multiplier[3]}}, bus.mul_multiplier};
    assign bus.mul_src_ready  = srcReadyEn && !mulHave;
    assign bus.mul_dest_valid = mulHave && (mulCnt == 2'd0);
    assign bus.mul_product    = mulProd;

    always @(posedge clk) begin
        if (rst) begin
            mulHave <= 1'b0;
            mulCnt  <= 2'd0;
            mulProd <= 8'sd0;
        end else if (!mulHave) begin
            if (bus.mul_src_valid && bus.mul_src_ready) begin
                mulHave <= 1'b1;
                mulCnt  <= 2'd2;
                mulProd <= mulA * mulB;
            end
        end else if (mulCnt != 2'd0) begin
            mulCnt <= mulCnt - 2'd1;
        end else if (bus.mul_dest_ready) begin
            mulHave <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input logic [3:0] a, input logic [3:0] b);
        if (lane == 0) begin
            bus.in_multiplicand[3:0] = a;
            bus.in_multiplier[3:0]   = b;
        end else begin
            bus.in_multiplicand[7:4] = a;
            bus.in_multiplier[7:4]   = b;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for a result, optionally hold it under backpressure, then accept it on the owner lane.
    task automatic serveOne(input logic [1:0] expOh, input logic [7:0] expProd, input string tag,
                            input int holdCycles, output int latency);
        latency = 0;
        do begin
            tick();
            latency++;
        end while (bus.out_valid == 2'b00 && latency < 30);
        checkOutput({tag, "_valid"}, 16'(bus.out_valid), 16'(expOh));
        checkOutput({tag, "_prod"}, 16'(bus.out_product), 16'(expProd));
        if (bus.out_valid != 2'b00) begin
            bus.out_ready = ~expOh;
            for (int i = 0; i < holdCycles; i++) begin
                tick();
                checkOutput({tag, "_holdValid"}, 16'(bus.out_valid), 16'(expOh));
                checkOutput({tag, "_holdProd"}, 16'(bus.out_product), 16'(expProd));
                checkOutput({tag, "_holdSrc"}, 16'(bus.mul_src_valid), 16'd0);
                checkOutput({tag, "_holdInReady"}, 16'(bus.in_ready), 16'd0);
            end
            bus.out_ready = expOh;
            tick();
            bus.out_ready = 2'b00;
            checkOutput({tag, "_release"}, 16'(bus.out_valid), 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks              = 0;
        errors              = 0;
        rst                 = 1'b1;
        srcReadyEn          = 1'b1;
        bus.in_valid        = 2'b00;
        bus.in_multiplicand = 8'h00;
        bus.in_multiplier   = 8'h00;
        bus.out_ready       = 2'b00;

        doReset();
        checkOutput("rst_inReady", 16'(bus.in_ready), 16'd0);
        checkOutput("rst_outValid", 16'(bus.out_valid), 16'd0);
        checkOutput("rst_outProd", 16'(bus.out_product), 16'd0);
        checkOutput("rst_srcValid", 16'(bus.mul_src_valid), 16'd0);
        checkOutput("rst_destReady", 16'(bus.mul_dest_ready), 16'd0);
        checkOutput("rst_mulA", 16'(bus.mul_multiplicand), 16'd0);
        checkOutput("rst_mulB", 16'(bus.mul_multiplier), 16'd0);

        // Single lane 0: 3 x -2, held under backpressure with non-owner out_ready asserted
        applyStimulus(0, 4'h3, 4'hE);
        bus.in_valid = 2'b01;
        #1;
        checkOutput("single_inReady", 16'(bus.in_ready), 16'h1);
        tick();
        checkOutput("single_srcValid", 16'(bus.mul_src_valid), 16'd1);
        checkOutput("single_mulA", 16'(bus.mul_multiplicand), 16'h3);
        checkOutput("single_mulB", 16'(bus.mul_multiplier), 16'hE);
        checkOutput("single_issueInReady", 16'(bus.in_ready), 16'd0);
        bus.in_valid = 2'b11;
        serveOne(2'b01, 8'hFA, "single", 5, lat);
        checkOutput("single_latency", 16'(lat), 16'd4);
        bus.in_valid = 2'b00;
        tick();
        checkOutput("drop_outValid", 16'(bus.out_valid), 16'd0);
        checkOutput("drop_prodHeld", 16'(bus.out_product), 16'hFA);
        checkOutput("drop_srcValid", 16'(bus.mul_src_valid), 16'd0);

        // Simultaneous requests after reset: lane 0 first, then lane 1
        doReset();
        applyStimulus(0, 4'h2, 4'h3);
        applyStimulus(1, 4'hC, 4'h5);
        bus.in_valid = 2'b11;
        #1;
        checkOutput("sim_inReady", 16'(bus.in_ready), 16'h1);
        serveOne(2'b01, 8'h06, "sim0", 0, lat);
        serveOne(2'b10, 8'hEC, "sim1", 0, lat);
        bus.in_valid = 2'b00;

        // Both lanes continuously valid: strict alternation starting at lane 0
        doReset();
        applyStimulus(0, 4'h2, 4'h2);
        applyStimulus(1, 4'hF, 4'h3);
        bus.in_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            serveOne((i % 2 == 1) ? 2'b10 : 2'b01, (i % 2 == 1) ? 8'hFD : 8'h04, "rr", 0, lat);
        end
        bus.in_valid = 2'b00;

        // Extreme operands, first one with the multiplier stalling its operand accept
        applyStimulus(1, 4'h8, 4'h8);
        bus.in_valid = 2'b10;
        srcReadyEn   = 1'b0;
        #1;
        checkOutput("ext0_inReady", 16'(bus.in_ready), 16'h2);
        tick();
        bus.in_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_srcValid", 16'(bus.mul_src_valid), 16'd1);
            checkOutput("stall_mulA", 16'(bus.mul_multiplicand), 16'h8);
        end
        srcReadyEn = 1'b1;
        serveOne(2'b10, 8'h40, "ext0", 0, lat);
        applyStimulus(0, 4'h8, 4'h7);
        bus.in_valid = 2'b01;
        tick();
        bus.in_valid = 2'b00;
        serveOne(2'b01, 8'hC8, "ext1", 0, lat);

        // Reset pulse while the multiplier is working on a lane 1 operation
        applyStimulus(1, 4'h3, 4'h3);
        bus.in_valid = 2'b10;
        tick();
        bus.in_valid = 2'b00;
        lat = 0;
        while (bus.mul_dest_ready == 1'b0 && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput("busy_destReady", 16'(bus.mul_dest_ready), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("busyRst_outValid", 16'(bus.out_valid), 16'd0);
        checkOutput("busyRst_outProd", 16'(bus.out_product), 16'd0);
        checkOutput("busyRst_srcValid", 16'(bus.mul_src_valid), 16'd0);
        checkOutput("busyRst_destReady", 16'(bus.mul_dest_ready), 16'd0);
        checkOutput("busyRst_mulA", 16'(bus.mul_multiplicand), 16'd0);
        checkOutput("busyRst_mulB", 16'(bus.mul_multiplier), 16'd0);
        applyStimulus(0, 4'h7, 4'hF);
        bus.in_valid = 2'b11;
        #1;
        checkOutput("busyRst_inReady", 16'(bus.in_ready), 16'h1);
        serveOne(2'b01, 8'hF9, "postRst", 0, lat);
        bus.in_valid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter MUL_WIDTH, default 4: operand width of the shared sequential multiplier.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 SHALL have port in_ready  output  2  per-requester request accept.
REQ-006 SHALL have port in_multiplicand  input  2*MUL_WIDTH  signed operand A; lane i at [i*MUL_WIDTH +: MUL_WIDTH].
REQ-007 SHALL have port in_multiplier  input  2*MUL_WIDTH  signed operand B; same lane packing.
REQ-008 SHALL have port out_valid  output  2  one-hot result valid; set bit = result owner.
REQ-009 SHALL have port out_ready  input  2  per-requester result accept.
REQ-010 SHALL have port out_product  output  2*MUL_WIDTH  signed result for the lane flagged in out_valid.
REQ-011 SHALL have port mul_src_valid  output  1  operand valid to multiplier.
REQ-012 SHALL have port mul_src_ready  input  1  multiplier accepts operands.
REQ-013 SHALL have port mul_multiplicand  output  MUL_WIDTH  operand A to multiplier.
REQ-014 SHALL have port mul_multiplier  output  MUL_WIDTH  operand B to multiplier.
REQ-015 SHALL have port mul_dest_valid  input  1  multiplier product valid.
REQ-016 SHALL have port mul_dest_ready  output  1  arbiter accepts product.
REQ-017 SHALL have port mul_product  input  2*MUL_WIDTH  signed product from multiplier.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> BUSY -> RESP -> IDLE; exactly one operation outstanding.
REQ-019 SHALL, in IDLE, assert in_ready only on the granted lane, combinationally from in_valid and priority pointer; all other states in_ready = 2'b00.
REQ-020 SHALL grant round-robin: both valid -> lane != last_served; one valid -> that lane; none -> no grant.
REQ-021 SHALL, on in_valid[g] & in_ready[g], latch lane g operands and owner id g, go to ISSUE next cycle.
REQ-022 SHALL, in ISSUE, drive mul_src_valid=1 with latched operands held stable until mul_src_ready=1, then go to BUSY.
REQ-023 SHALL, in BUSY, drive mul_dest_ready=1; on mul_dest_valid=1 capture mul_product into result register, go to RESP; mul_dest_ready=0 in all other states.
REQ-024 SHALL, in RESP, drive out_valid = one-hot(owner), out_product = result; hold both stable until out_ready[owner]=1, then set last_served=owner and go to IDLE.
REQ-025 SHALL ignore out_ready on non-owner lanes and mul_dest_valid outside BUSY.
REQ-026 SHALL hold out_product at last result when out_valid=0.
REQ-027 SHALL add no cycles beyond one per state transition: in handshake at cycle 0 -> mul_src_valid at cycle 1 -> out_valid one cycle after mul_dest_valid handshake.
REQ-028 SHALL allow a requester to drop in_valid before grant with no state change.
REQ-029 SHALL not re-issue or drop an operation under result backpressure.

Reset
REQ-030 SHALL, on rst=1 at a clock edge in any state, go to IDLE, abandon in-flight operation, clear result to 0, set last_served=1 (lane 0 favoured).
REQ-031 SHALL drive after reset: in_ready per REQ-019, out_valid=0, out_product=0, mul_src_valid=0, mul_dest_ready=0, mul_multiplicand=0, mul_multiplier=0.

Verification (MUL_WIDTH=4, real multiplier attached)
REQ-032 SHALL check single lane 0: 3 x -2 -> out_valid=2'b01, out_product=8'hFA, held until out_ready[0].
REQ-033 SHALL check simultaneous: lane0 2x3, lane1 -4x5 after reset -> lane0 result 8'h06 first, then lane1 8'hEC.
REQ-034 SHALL check both lanes continuously valid for 6 operations -> grant order 0,1,0,1,0,1.
REQ-035 SHALL check out_ready low 5 cycles in RESP -> out_valid/out_product stable, mul_src_valid=0, in_ready=2'b00.
REQ-036 SHALL check extreme operands: -8 x -8 -> 8'h40; -8 x 7 -> 8'hC8.
REQ-037 SHALL check rst pulse during BUSY -> next cycle IDLE, all outputs per REQ-031, next request from lane 0 granted first.
